// File: rtl/axi_write_controller_pkg.sv
// Shared definitions for the merger-tree output packer: FSM encoding, lane
// geometry helpers and the end-of-stream terminator value.
package axi_write_controller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t FILL = 2'd0;
    localparam state_t HOLD = 2'd1;
    localparam state_t SEND = 2'd2;

    // A zero element marks end of stream; payload elements are never zero.
    localparam int TERMINATOR = 0;

    function automatic int lanes_of(input int tdata_width, input int elem_width);
        return tdata_width / elem_width;
    endfunction

    function automatic int lane_w_of(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/axi_write_controller.sv
// Packs 32-bit sorted elements from a FWFT FIFO into wide AXI4-Stream beats,
// turning the zero terminator into tlast. Optional beat counter: AXI_WRITE_BEAT_CNT_EN.
module axi_write_controller
    import axi_write_controller_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_SORTER_BIT_WIDTH = 32
) (
    input  logic                          m_axis_aclk,
    input  logic                          m_axis_areset,
    input  logic                          out_fifo_empty,
    input  logic [C_SORTER_BIT_WIDTH-1:0] out_fifo_data,
    output logic                          out_fifo_rd_en,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast
`ifdef AXI_WRITE_BEAT_CNT_EN
    ,
    output logic [31:0]                   beat_cnt
`endif
);

    localparam int LANES  = lanes_of(C_AXIS_TDATA_WIDTH, C_SORTER_BIT_WIDTH);
    localparam int LANE_W = lane_w_of(LANES);
    localparam logic [C_SORTER_BIT_WIDTH-1:0] TERM = C_SORTER_BIT_WIDTH'(TERMINATOR);

    state_t                                    state;
    logic [LANE_W-1:0]                         lane;
    logic [LANES-1:0][C_SORTER_BIT_WIDTH-1:0]  acc;
    logic                                      tlast_q;

    logic is_term;
    logic last_lane;

    assign is_term   = (out_fifo_data == TERM);
    assign last_lane = (lane == LANE_W'(LANES - 1));

    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tdata  = acc;
    assign m_axis_tlast  = tlast_q;

    // In HOLD the head is only inspected; it is popped solely when it is the terminator.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        out_fifo_rd_en = 1'b0;
        if (!m_axis_areset && !out_fifo_empty) begin
            case (state)
                FILL:    out_fifo_rd_en = 1'b1;
                HOLD:    out_fifo_rd_en = is_term;
                default: out_fifo_rd_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (m_axis_areset) begin
            state   <= FILL;
            lane    <= '0;
            // NOTE: the accumulator is a plain register bank, not a RAM, so it can and must reset to keep tdata=0.
            acc     <= '0;
            tlast_q <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (!out_fifo_empty) begin
                        if (is_term) begin
                            for (int i = 0; i < LANES; i++) begin
                                if (i >= int'(lane)) acc[i] <= '0;
                            end
                            tlast_q <= 1'b1;
                            state   <= SEND;
                        end else begin
                            acc[lane] <= out_fifo_data;
                            if (last_lane) state <= HOLD;
                            else           lane  <= lane + LANE_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Lookahead lets a terminator right after a full word ride on that word.
                    if (!out_fifo_empty) begin
                        tlast_q <= is_term;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (m_axis_tready) begin
                        acc     <= '0;
                        lane    <= '0;
                        tlast_q <= 1'b0;
                        state   <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                    lane  <= '0;
                end
            endcase
        end
    end

`ifdef AXI_WRITE_BEAT_CNT_EN
    // Free-running handshake count across streams; only reset clears it.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset)                       beat_cnt <= '0;
        else if (m_axis_tvalid && m_axis_tready) beat_cnt <= beat_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/axi_write_controller.md
# axi_write_controller

Output-side packer for the merger tree: drains 32-bit sorted elements from the tree's output FIFO and packs 16 of them into each 512-bit AXI4-Stream beat for the write DMA. A 0-valued element is the end-of-stream terminator, matching the extra 0 the input side appends after `s_axis_tlast`. The terminator is consumed, never transmitted as data, and converted into `m_axis_tlast` on the final beat.

## Interface
- `C_AXIS_TDATA_WIDTH`, 512: output beat width.
- `C_SORTER_BIT_WIDTH`, 32: element width. `C_AXIS_TDATA_WIDTH/C_SORTER_BIT_WIDTH` must be an integer ≥2 (LANES, 16 by default).
- `m_axis_aclk`  in  1  clock.
- `m_axis_areset`  in  1  reset; **synchronous, active-high** (the "a" is naming only).
- `out_fifo_empty`  in  1  tree output FIFO empty; the FIFO is first-word-fall-through.
- `out_fifo_data`  in  C_SORTER_BIT_WIDTH  FIFO head element; valid when `out_fifo_empty`=0.
- `out_fifo_rd_en`  out  1  pop the head element.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  C_AXIS_TDATA_WIDTH  packed beat; lane i occupies `[32i+31:32i]`, and lane 0 is the first element popped.
- `m_axis_tlast`  out  1  final beat of the stream.

## Operation
- State `FILL` (lane counter 0..LANES-1, accumulator register):
  - Head nonzero and FIFO not empty: pop, write the element to the current lane, increment the lane.
  - Writing lane LANES-1 moves to `HOLD`.
  - Head == 0 with lane > 0: pop, zero-fill lanes lane..LANES-1, set tlast=1, go to `SEND`.
  - Head == 0 with lane == 0 (empty stream): pop, send an all-zero beat with tlast=1, go to `SEND`.
- State `HOLD` (full word, tvalid still 0): wait for FIFO not empty, then look ahead at the head.
  - Head == 0: pop it, set tlast=1, go to `SEND`.
  - Head nonzero: do not pop, set tlast=0, go to `SEND`.
- State `SEND`: tvalid=1. On tvalid&tready, clear the accumulator, set lane=0, go to `FILL`. Stream boundaries need no idle state.
- `out_fifo_rd_en` is combinational: (`FILL` or `HOLD`) & !`out_fifo_empty`, with the `HOLD` pop only on a terminator. It is forced to 0 while `m_axis_areset`=1 and in `SEND`.
- Payload elements are nonzero by system contract. No check is made.
- Any state other than the three above decodes to `FILL` with lane 0.

## Timing
- Reset values: state `FILL`, lane 0, accumulator 0. Outputs: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `out_fifo_rd_en`=0.
- One element is popped per cycle while the FIFO is non-empty.
- Full beat, best case: 16 pop cycles + 1 `HOLD` cycle + ≥1 `SEND` cycle. tvalid rises the cycle after the lookahead decision.
- While tvalid=1 and tready=0, tdata and tlast are held stable and tvalid is not withdrawn.
- FIFO empty in `FILL` or `HOLD`: stall indefinitely. Partial data is retained.
- Terminator directly after a full word: no extra beat; tlast rides on that word.
- Reset mid-operation: partial word discarded, tvalid=0 on the next edge. Elements already popped are lost, so the system resets the tree together with this block.

## Configuration
- `AXI_WRITE_BEAT_CNT_EN` defined: adds output `beat_cnt` [31:0].
  - Increments on every tvalid&tready.
  - Reset to 0 by `m_axis_areset` only; not cleared by tlast.
  - Wraps at 2^32.
- Not defined: the port and the counter do not exist. All other behaviour is identical.

## Structure
- Shared package holds:
  - state encoding localparams (`FILL`, `HOLD`, `SEND`);
  - `LANES` derivation and the lane-counter width (clog2 of LANES);
  - the terminator constant (0).
- No sub-module: the packer, FSM and optional counter form one module.

## Test plan
- 32 elements 1..32, then 0, FIFO always non-empty, tready=1 → 2 beats. Beat0 lanes 1..16 with tlast=0; beat1 lanes 17..32 with tlast=1. 33 pops total.
- 5 elements 7,7,7,7,7, then 0 → 1 beat: lanes 0..4 = 7, lanes 5..15 = 0, tlast=1.
- Only 0 in the FIFO → 1 beat, tdata=0, tlast=1.
- 16 elements, then tready held low 10 cycles after tvalid → tdata and tlast stable over all 10 cycles. tvalid is not asserted until the 17th FIFO entry (0) appears, then tlast=1.
- FIFO empties after 9 elements for 20 cycles, then delivers 7 more plus 0 → a single beat with lanes 0..15 in order and tlast=1. No rd_en pulses during the gap.
- Reset asserted after 6 pops → tvalid=0, lane counter 0. A following stream 100..115, then 0, yields one clean beat with tlast=1. With the macro defined, `beat_cnt`=1.
